bank_isu_lf_sched: RTL and testbench
====================================

Name: bank_isu_lf_sched

Overview:
Linefill request scheduler for one bank. Queues linefill requests raised when the hit-test stage misses, and issues them one at a time to the bus interface unit read-address channel with arid = {set,way}. Tracks outstanding reads against a credit limit. Clears per-line in-flight state when the matching read-data beat returns, so the same {set,way} never has two fills in flight.

Parameters:
- QDEPTH, 4, pending-request queue entries; power of two, minimum 2.
- MAX_OUTST, 4, maximum issued-but-unreturned reads; range 1..15.
- ADDR_WIDTH, 32, linefill line address width.
- TIMEOUT_CYC, 1023, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- lf_req_valid_i  in  1  linefill request valid
- lf_req_ready_o  out  1  request accepted when valid & ready
- lf_req_set_i  in  3  cache set
- lf_req_way_i  in  3  victim way
- lf_req_addr_i  in  ADDR_WIDTH  line address
- biu_arvalid_o  out  1  read-address valid
- biu_arready_i  in  1  read-address ready
- biu_arid_o  out  6  {set[2:0],way[2:0]}
- biu_araddr_o  out  ADDR_WIDTH  line address
- biu_rvalid_i  in  1  read data valid (observed only)
- biu_rready_i  in  1  read data ready, driven by the issue unit
- biu_rid_i  in  6  returning {set,way}
- drain_i  in  1  stop issuing new reads
- drain_done_o  out  1  queue empty, zero outstanding, FSM in IDLE
- outst_cnt_o  out  4  current outstanding count
- lf_err_o  out  1  sticky error

Behaviour:
- Reset values:
  - ready=1, arvalid=0, arid=0, araddr=0, outst_cnt=0, lf_err=0, drain_done=1.
  - Queue empty, in-flight bitmap all 0, FSM=IDLE.
- In-flight bitmap (64 bits, index {set,way}):
  - A bit is set on request accept and cleared on return (biu_rvalid_i & biu_rready_i) for biu_rid_i.
  - A bit therefore covers both queued and issued lines.
- Accept rule: lf_req_ready_o = !queue_full & !bitmap[{set,way}] of the current input.
  - It is combinational on the inputs; a duplicate request stalls until the earlier fill returns.
  - Same-cycle return of the same {set,way} does not open ready that cycle; the bit is still set.
- Return for a {set,way} whose bit is clear: ignore the return, set lf_err_o, leave outst_cnt unchanged.
- FSM:
  - IDLE: moves to ISSUE when queue non-empty & !drain_i & outst_cnt<MAX_OUTST. Moves to WAIT_CRED when queue non-empty & outst_cnt==MAX_OUTST.
  - ISSUE:
    - arvalid=1; arid and araddr come from a registered copy of the queue head.
    - Held stable until arready; drain_i does not withdraw a valid already asserted.
    - On handshake: pop the head, outst_cnt+1, then go to IDLE.
    - Minimum one idle cycle between issues, so peak rate is one AR per 2 cycles.
  - WAIT_CRED: returns to IDLE on any return handshake.
- Latency: request accepted at cycle N into an empty queue, with credit available, gives arvalid at N+2 (registered enqueue, then FSM).
- Counter:
  - Simultaneous AR handshake and valid return leaves outst_cnt unchanged.
  - A return with outst_cnt==0 sets lf_err_o; the counter saturates at 0.
- Queue is a circular buffer with wrap-around pointers plus an extra wrap bit for full/empty. Enqueue and dequeue in the same cycle are allowed when full.
- drain_done_o = queue_empty & outst_cnt==0 & state==IDLE, registered.
- Reset mid-operation drops all queued and outstanding state. Returns arriving after reset count as spurious and set lf_err_o.

Optional Feature:
- Macro: BANK_ISU_LF_TIMEOUT_EN.
- Enabled:
  - A watchdog counter increments while outst_cnt>0 and clears on every return handshake.
  - When it reaches TIMEOUT_CYC it sets lf_err_o (sticky) and holds its value.
- Disabled: no counter logic; lf_err_o reflects only the spurious and underflow errors.

Decomposition:
- Shared package: LF_ID_WIDTH=6, set/way field widths, FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_CRED=2'd2), default MAX_OUTST and QDEPTH.
- One sub-module, bank_isu_lf_queue: parameterised FIFO holding {set,way,addr}, with full/empty and a combinational head.
- The bitmap, FSM and counters live in the top.

Test Plan:
- Single request set=3 way=5 addr=0x1000 with arready=1 → arvalid at cycle +2, arid=6'h1D, araddr=0x1000. Return rid=0x1D → outst_cnt 1→0, drain_done=1.
- Duplicate: accept set=2 way=1, re-present the same request → ready=0 until return rid=0x11, then accepted next cycle.
- Credit limit MAX_OUTST=4: 5 distinct requests with no returns → 4 AR handshakes, FSM in WAIT_CRED. One return → 5th AR issues.
- Backpressure: arready=0 for 10 cycles → arvalid, arid and araddr held stable. Assert drain_i during the stall → the in-progress AR still completes and no further AR issues.
- Spurious return rid=0x3F with empty bitmap → lf_err_o=1 and stays 1; outst_cnt stays 0.
- With BANK_ISU_LF_TIMEOUT_EN, TIMEOUT_CYC=20: issue one AR with no return → lf_err_o rises exactly 20 cycles after the count became nonzero.

Source files
------------

// File: rtl/bank_isu_lf_sched_pkg.sv
// Shared definitions for the bank linefill scheduler: identifier widths,
// FSM state encodings and default sizing.
package bank_isu_lf_sched_pkg;

    localparam int LF_SET_WIDTH  = 3;
    localparam int LF_WAY_WIDTH  = 3;
    localparam int LF_ID_WIDTH   = LF_SET_WIDTH + LF_WAY_WIDTH;
    localparam int LF_ID_COUNT   = 1 << LF_ID_WIDTH;

    localparam int DEF_QDEPTH    = 4;
    localparam int DEF_MAX_OUTST = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_CRED = 2'd2;

    typedef logic [LF_SET_WIDTH-1:0] lf_set_t;
    typedef logic [LF_WAY_WIDTH-1:0] lf_way_t;
    typedef logic [LF_ID_WIDTH-1:0]  lf_id_t;

    // Line identifier used both as the in-flight index and as the AR id.
    function automatic lf_id_t lf_id(input lf_set_t set, input lf_way_t way);
        return {set, way};
    endfunction

endpackage

// File: rtl/bank_isu_lf_queue.sv
// Pending linefill request FIFO. Circular buffer with an extra wrap bit on
// each pointer to tell full from empty; head is read combinationally.
// A push while full is taken only when a pop happens in the same cycle.
module bank_isu_lf_queue
    import bank_isu_lf_sched_pkg::*;
#(
    parameter int QDEPTH = DEF_QDEPTH,
    parameter int WIDTH  = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [WIDTH-1:0] mem [QDEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    // Pointer advance; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/bank_isu_lf_sched.sv
// Linefill request scheduler for one cache bank. Queues miss requests,
// issues them one at a time on the BIU read-address channel with
// arid = {set,way}, limits outstanding reads, and keeps a per-line
// in-flight bitmap so one {set,way} never has two fills in flight.
// Optional watchdog: define BANK_ISU_LF_TIMEOUT_EN.
module bank_isu_lf_sched
    import bank_isu_lf_sched_pkg::*;
#(
    parameter int QDEPTH      = DEF_QDEPTH,
    parameter int MAX_OUTST   = DEF_MAX_OUTST,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   lf_req_valid_i,
    output logic                   lf_req_ready_o,
    input  logic [2:0]             lf_req_set_i,
    input  logic [2:0]             lf_req_way_i,
    input  logic [ADDR_WIDTH-1:0]  lf_req_addr_i,
    output logic                   biu_arvalid_o,
    input  logic                   biu_arready_i,
    output logic [5:0]             biu_arid_o,
    output logic [ADDR_WIDTH-1:0]  biu_araddr_o,
    input  logic                   biu_rvalid_i,
    input  logic                   biu_rready_i,
    input  logic [5:0]             biu_rid_i,
    input  logic                   drain_i,
    output logic                   drain_done_o,
    output logic [3:0]             outst_cnt_o,
    output logic                   lf_err_o
);

    localparam int         ENTRY_W = LF_ID_WIDTH + ADDR_WIDTH;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    // Reject configurations the counters and queue cannot represent.
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || MAX_OUTST < 1 ||
        MAX_OUTST > 15 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("bank_isu_lf_sched: unsupported parameter combination");
    end

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   load_head;
    logic [LF_ID_COUNT-1:0] in_flight;
    logic [3:0]             outst_cnt;
    logic                   lf_err;

    logic                   q_full;
    logic                   q_empty;
    logic [ENTRY_W-1:0]     q_head;
    logic [ENTRY_W-1:0]     q_push_data;

    lf_id_t                 req_id;
    logic                   accept;
    logic                   ar_hs;
    logic                   ret;
    logic                   ret_hit;
    logic                   ret_spurious;
    logic                   ret_underflow;
    logic                   ret_dec;
    logic                   wd_fire;

    assign req_id        = lf_id(lf_req_set_i, lf_req_way_i);
    assign lf_req_ready_o = !q_full && !in_flight[req_id];
    assign accept        = lf_req_valid_i && lf_req_ready_o;
    assign q_push_data   = {req_id, lf_req_addr_i};

    assign biu_arvalid_o = (state == ST_ISSUE);
    assign ar_hs         = biu_arvalid_o && biu_arready_i;

    assign ret           = biu_rvalid_i && biu_rready_i;
    assign ret_hit       = ret && in_flight[biu_rid_i];
    assign ret_spurious  = ret && !in_flight[biu_rid_i];
    assign ret_underflow = ret && (outst_cnt == 4'd0);
    assign ret_dec       = ret_hit && (outst_cnt != 4'd0);

    assign outst_cnt_o   = outst_cnt;
    assign lf_err_o      = lf_err;

    bank_isu_lf_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (ENTRY_W)
    ) u_queue (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (accept),
        .push_data (q_push_data),
        .pop       (ar_hs),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Next-state logic; the head is latched into the AR registers on IDLE->ISSUE.
    always_comb begin
        state_nxt = state;
        load_head = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    if (outst_cnt >= MAX_CNT) begin
                        state_nxt = ST_WAIT_CRED;
                    end else if (!drain_i) begin
                        state_nxt = ST_ISSUE;
                        load_head = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (biu_arready_i) state_nxt = ST_IDLE;
            end
            ST_WAIT_CRED: begin
                if (ret) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // AR payload registers, held stable for the whole ISSUE state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            biu_arid_o   <= '0;
            biu_araddr_o <= '0;
        end else if (load_head) begin
            biu_arid_o   <= q_head[ENTRY_W-1 -: LF_ID_WIDTH];
            biu_araddr_o <= q_head[ADDR_WIDTH-1:0];
        end
    end

    // In-flight bitmap: set on accept, cleared on a matching return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_flight <= '0;
        end else begin
            if (ret_hit) in_flight[biu_rid_i] <= 1'b0;
            if (accept)  in_flight[req_id]    <= 1'b1;
        end
    end

    // Outstanding-read counter; saturates at zero on an unmatched return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_cnt <= 4'd0;
        end else begin
            case ({ar_hs, ret_dec})
                2'b10:   outst_cnt <= outst_cnt + 4'd1;
                2'b01:   outst_cnt <= outst_cnt - 4'd1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

    // Registered drain-complete indication.
    always_ff @(posedge clk_i) begin
        if (rst_i) drain_done_o <= 1'b1;
        else       drain_done_o <= q_empty && (outst_cnt == 4'd0) && (state == ST_IDLE);
    end

`ifdef BANK_ISU_LF_TIMEOUT_EN
    localparam int             WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_inc;

    assign wd_inc  = (outst_cnt != 4'd0) && !ret && (wd_cnt != WD_LIMIT);
    // Fire on the edge where the count reaches the limit.
    assign wd_fire = wd_inc && (wd_cnt == WD_LIMIT - 1'b1);

    // Watchdog: counts while reads are outstanding, restarts on any return.
    always_ff @(posedge clk_i) begin
        if (rst_i || ret) wd_cnt <= '0;
        else if (wd_inc)  wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    // Sticky error: spurious return, counter underflow or watchdog expiry.
    always_ff @(posedge clk_i) begin
        if (rst_i) lf_err <= 1'b0;
        else       lf_err <= lf_err || ret_spurious || ret_underflow || wd_fire;
    end

endmodule

// File: tb/tb_bank_isu_lf_sched.sv
// Directed self-checking bench for bank_isu_lf_sched.
module tb_bank_isu_lf_sched;

    localparam int ADDR_WIDTH = 32;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  lf_req_valid_i;
    logic                  lf_req_ready_o;
    logic [2:0]            lf_req_set_i;
    logic [2:0]            lf_req_way_i;
    logic [ADDR_WIDTH-1:0] lf_req_addr_i;
    logic                  biu_arvalid_o;
    logic                  biu_arready_i;
    logic [5:0]            biu_arid_o;
    logic [ADDR_WIDTH-1:0] biu_araddr_o;
    logic                  biu_rvalid_i;
    logic                  biu_rready_i;
    logic [5:0]            biu_rid_i;
    logic                  drain_i;
    logic                  drain_done_o;
    logic [3:0]            outst_cnt_o;
    logic                  lf_err_o;

    int checks_total = 0;
    int checks_pass  = 0;
    int ar_cnt       = 0;

    bank_isu_lf_sched #(
        .QDEPTH      (4),
        .MAX_OUTST   (4),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lf_req_valid_i (lf_req_valid_i),
        .lf_req_ready_o (lf_req_ready_o),
        .lf_req_set_i   (lf_req_set_i),
        .lf_req_way_i   (lf_req_way_i),
        .lf_req_addr_i  (lf_req_addr_i),
        .biu_arvalid_o  (biu_arvalid_o),
        .biu_arready_i  (biu_arready_i),
        .biu_arid_o     (biu_arid_o),
        .biu_araddr_o   (biu_araddr_o),
        .biu_rvalid_i   (biu_rvalid_i),
        .biu_rready_i   (biu_rready_i),
        .biu_rid_i      (biu_rid_i),
        .drain_i        (drain_i),
        .drain_done_o   (drain_done_o),
        .outst_cnt_o    (outst_cnt_o),
        .lf_err_o       (lf_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (biu_arvalid_o && biu_arready_i) ar_cnt <= ar_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_req(input logic [2:0] set, input logic [2:0] way,
                            input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        lf_req_valid_i = 1'b1;
        lf_req_set_i   = set;
        lf_req_way_i   = way;
        lf_req_addr_i  = addr;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (lf_req_ready_o) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        lf_req_valid_i = 1'b0;
    endtask

    task automatic wait_arvalid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (biu_arvalid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_return(input logic [5:0] id);
        biu_rvalid_i = 1'b1;
        biu_rready_i = 1'b1;
        biu_rid_i    = id;
        tick();
        biu_rvalid_i = 1'b0;
        biu_rready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checks_total++;
        if (lf_req_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", lf_req_ready_o);
        else checks_pass++;
        checks_total++;
        if (biu_arvalid_o !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", biu_arvalid_o);
        else checks_pass++;
        checks_total++;
        if (biu_arid_o !== 6'h00) $display("FAIL reset_arid: got %h want 00", biu_arid_o);
        else checks_pass++;
        checks_total++;
        if (biu_araddr_o !== 32'h0) $display("FAIL reset_araddr: got %h want 0", biu_araddr_o);
        else checks_pass++;
        checks_total++;
        if (outst_cnt_o !== 4'd0) $display("FAIL reset_outst: got %0d want 0", outst_cnt_o);
        else checks_pass++;
        checks_total++;
        if (lf_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", lf_err_o);
        else checks_pass++;
        checks_total++;
        if (drain_done_o !== 1'b1) $display("FAIL reset_drain_done: got %b want 1", drain_done_o);
        else checks_pass++;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        biu_arready_i = 1'b1;
        push_req(3'd3, 3'd5, 32'h1000, ok);
        checks_total++;
        if (ok !== 1'b1 || biu_arvalid_o !== 1'b0)
            $display("FAIL single_accept: accepted %b arvalid %b want 1/0", ok, biu_arvalid_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (biu_arvalid_o !== 1'b1 || biu_arid_o !== 6'h1D || biu_araddr_o !== 32'h1000)
            $display("FAIL single_ar: arvalid %b arid %h araddr %h want 1/1d/1000",
                     biu_arvalid_o, biu_arid_o, biu_araddr_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (biu_arvalid_o !== 1'b0 || outst_cnt_o !== 4'd1 || drain_done_o !== 1'b0)
            $display("FAIL single_issued: arvalid %b outst %0d drain_done %b want 0/1/0",
                     biu_arvalid_o, outst_cnt_o, drain_done_o);
        else checks_pass++;
        do_return(6'h1D);
        checks_total++;
        if (outst_cnt_o !== 4'd0 || lf_err_o !== 1'b0)
            $display("FAIL single_return: outst %0d err %b want 0/0", outst_cnt_o, lf_err_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (drain_done_o !== 1'b1) $display("FAIL single_drain_done: got %b want 1", drain_done_o);
        else checks_pass++;
    endtask

    task automatic test_duplicate();
        bit ok;
        push_req(3'd2, 3'd1, 32'h2000, ok);
        lf_req_valid_i = 1'b1;
        lf_req_set_i   = 3'd2;
        lf_req_way_i   = 3'd1;
        lf_req_addr_i  = 32'h2400;
        #1;
        checks_total++;
        if (ok !== 1'b1 || lf_req_ready_o !== 1'b0)
            $display("FAIL dup_blocked: first %b ready %b want 1/0", ok, lf_req_ready_o);
        else checks_pass++;
        tick();
        tick();
        tick();
        checks_total++;
        if (lf_req_ready_o !== 1'b0 || outst_cnt_o !== 4'd1)
            $display("FAIL dup_still_blocked: ready %b outst %0d want 0/1", lf_req_ready_o, outst_cnt_o);
        else checks_pass++;
        biu_rvalid_i = 1'b1;
        biu_rready_i = 1'b1;
        biu_rid_i    = 6'h11;
        #1;
        checks_total++;
        if (lf_req_ready_o !== 1'b0)
            $display("FAIL dup_same_cycle: ready %b want 0", lf_req_ready_o);
        else checks_pass++;
        tick();
        biu_rvalid_i = 1'b0;
        biu_rready_i = 1'b0;
        #1;
        checks_total++;
        if (lf_req_ready_o !== 1'b1 || outst_cnt_o !== 4'd0)
            $display("FAIL dup_reopen: ready %b outst %0d want 1/0", lf_req_ready_o, outst_cnt_o);
        else checks_pass++;
        tick();
        lf_req_valid_i = 1'b0;
        wait_arvalid(ok);
        checks_total++;
        if (ok !== 1'b1 || biu_arid_o !== 6'h11 || biu_araddr_o !== 32'h2400)
            $display("FAIL dup_reissue: seen %b arid %h araddr %h want 1/11/2400",
                     ok, biu_arid_o, biu_araddr_o);
        else checks_pass++;
        tick();
        do_return(6'h11);
        checks_total++;
        if (outst_cnt_o !== 4'd0 || lf_err_o !== 1'b0)
            $display("FAIL dup_cleanup: outst %0d err %b want 0/0", outst_cnt_o, lf_err_o);
        else checks_pass++;
    endtask

    task automatic test_credit();
        bit ok;
        bit all_ok;
        int ar_start;
        logic [2:0] sets [5] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
        logic [2:0] ways [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        all_ok   = 1'b1;
        ar_start = ar_cnt;
        for (int i = 0; i < 5; i++) begin
            push_req(sets[i], ways[i], 32'h4000 + 32'(i) * 32'h40, ok);
            if (!ok) all_ok = 1'b0;
        end
        repeat (20) tick();
        checks_total++;
        if (all_ok !== 1'b1 || ar_cnt - ar_start != 4)
            $display("FAIL credit_limit: accepted %b ar %0d want 1/4", all_ok, ar_cnt - ar_start);
        else checks_pass++;
        checks_total++;
        if (outst_cnt_o !== 4'd4 || dut.state !== 2'd2 || biu_arvalid_o !== 1'b0)
            $display("FAIL credit_wait: outst %0d state %0d arvalid %b want 4/2/0",
                     outst_cnt_o, dut.state, biu_arvalid_o);
        else checks_pass++;
        do_return(6'h20);
        wait_arvalid(ok);
        checks_total++;
        if (ok !== 1'b1 || biu_arid_o !== 6'h28 || biu_araddr_o !== 32'h4100)
            $display("FAIL credit_fifth: seen %b arid %h araddr %h want 1/28/4100",
                     ok, biu_arid_o, biu_araddr_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (outst_cnt_o !== 4'd4 || ar_cnt - ar_start != 5)
            $display("FAIL credit_refill: outst %0d ar %0d want 4/5", outst_cnt_o, ar_cnt - ar_start);
        else checks_pass++;
        do_return(6'h21);
        do_return(6'h22);
        do_return(6'h23);
        do_return(6'h28);
        checks_total++;
        if (outst_cnt_o !== 4'd0 || lf_err_o !== 1'b0)
            $display("FAIL credit_cleanup: outst %0d err %b want 0/0", outst_cnt_o, lf_err_o);
        else checks_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        int ar_start;
        biu_arready_i = 1'b0;
        ar_start = ar_cnt;
        push_req(3'd6, 3'd2, 32'hABCD0, ok);
        wait_arvalid(ok);
        stable = ok;
        for (int i = 0; i < 10; i++) begin
            if (!(biu_arvalid_o === 1'b1 && biu_arid_o === 6'h32 && biu_araddr_o === 32'hABCD0))
                stable = 1'b0;
            if (i == 2) begin
                lf_req_valid_i = 1'b1;
                lf_req_set_i   = 3'd7;
                lf_req_way_i   = 3'd7;
                lf_req_addr_i  = 32'h7000;
            end
            if (i == 3) begin
                lf_req_valid_i = 1'b0;
                drain_i        = 1'b1;
            end
            tick();
        end
        checks_total++;
        if (stable !== 1'b1)
            $display("FAIL bp_stable: arvalid %b arid %h araddr %h want held 1/32/abcd0",
                     biu_arvalid_o, biu_arid_o, biu_araddr_o);
        else checks_pass++;
        biu_arready_i = 1'b1;
        tick();
        checks_total++;
        if (biu_arvalid_o !== 1'b0 || outst_cnt_o !== 4'd1)
            $display("FAIL bp_complete: arvalid %b outst %0d want 0/1", biu_arvalid_o, outst_cnt_o);
        else checks_pass++;
        repeat (10) tick();
        checks_total++;
        if (ar_cnt - ar_start != 1 || biu_arvalid_o !== 1'b0 || drain_done_o !== 1'b0)
            $display("FAIL bp_drain_hold: ar %0d arvalid %b drain_done %b want 1/0/0",
                     ar_cnt - ar_start, biu_arvalid_o, drain_done_o);
        else checks_pass++;
        drain_i = 1'b0;
        wait_arvalid(ok);
        checks_total++;
        if (ok !== 1'b1 || biu_arid_o !== 6'h3F || biu_araddr_o !== 32'h7000)
            $display("FAIL bp_resume: seen %b arid %h araddr %h want 1/3f/7000",
                     ok, biu_arid_o, biu_araddr_o);
        else checks_pass++;
        tick();
        do_return(6'h32);
        do_return(6'h3F);
        tick();
        checks_total++;
        if (drain_done_o !== 1'b1 || outst_cnt_o !== 4'd0 || lf_err_o !== 1'b0)
            $display("FAIL bp_cleanup: drain_done %b outst %0d err %b want 1/0/0",
                     drain_done_o, outst_cnt_o, lf_err_o);
        else checks_pass++;
    endtask

    task automatic test_spurious();
        do_return(6'h3F);
        checks_total++;
        if (lf_err_o !== 1'b1 || outst_cnt_o !== 4'd0)
            $display("FAIL spur_err: err %b outst %0d want 1/0", lf_err_o, outst_cnt_o);
        else checks_pass++;
        repeat (5) tick();
        checks_total++;
        if (lf_err_o !== 1'b1 || outst_cnt_o !== 4'd0)
            $display("FAIL spur_sticky: err %b outst %0d want 1/0", lf_err_o, outst_cnt_o);
        else checks_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit ok2;
        int ar_start;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks_total++;
        if (lf_err_o !== 1'b0) $display("FAIL rmid_err_clear: got %b want 0", lf_err_o);
        else checks_pass++;
        push_req(3'd1, 3'd1, 32'h100, ok);
        wait_arvalid(ok2);
        tick();
        push_req(3'd1, 3'd2, 32'h200, ok);
        checks_total++;
        if (ok !== 1'b1 || ok2 !== 1'b1 || outst_cnt_o !== 4'd1)
            $display("FAIL rmid_setup: ok %b/%b outst %0d want 1/1/1", ok, ok2, outst_cnt_o);
        else checks_pass++;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        ar_start = ar_cnt;
        checks_total++;
        if (outst_cnt_o !== 4'd0 || biu_arvalid_o !== 1'b0 || drain_done_o !== 1'b1)
            $display("FAIL rmid_state: outst %0d arvalid %b drain_done %b want 0/0/1",
                     outst_cnt_o, biu_arvalid_o, drain_done_o);
        else checks_pass++;
        do_return(6'h09);
        repeat (5) tick();
        checks_total++;
        if (lf_err_o !== 1'b1 || outst_cnt_o !== 4'd0 || ar_cnt != ar_start)
            $display("FAIL rmid_late_return: err %b outst %0d ar %0d want 1/0/0",
                     lf_err_o, outst_cnt_o, ar_cnt - ar_start);
        else checks_pass++;
    endtask

`ifdef BANK_ISU_LF_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        push_req(3'd0, 3'd1, 32'h40, ok);
        wait_arvalid(ok);
        tick();
        repeat (19) tick();
        checks_total++;
        if (ok !== 1'b1 || lf_err_o !== 1'b0 || outst_cnt_o !== 4'd1)
            $display("FAIL timeout_early: seen %b err %b outst %0d want 1/0/1", ok, lf_err_o, outst_cnt_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (lf_err_o !== 1'b1) $display("FAIL timeout_fire: err %b want 1", lf_err_o);
        else checks_pass++;
    endtask
`endif

    initial begin
        rst_i          = 1'b1;
        lf_req_valid_i = 1'b0;
        lf_req_set_i   = 3'd0;
        lf_req_way_i   = 3'd0;
        lf_req_addr_i  = '0;
        biu_arready_i  = 1'b1;
        biu_rvalid_i   = 1'b0;
        biu_rready_i   = 1'b0;
        biu_rid_i      = 6'd0;
        drain_i        = 1'b0;
        test_reset();
        test_single();
        test_duplicate();
        test_credit();
        test_backpressure();
        test_spurious();
        test_reset_mid();
`ifdef BANK_ISU_LF_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
